mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the instruction-fetch/load-store requesters, the arbiter
// and the shared byte-wide RAM/IO port.
interface mem_port_arbiter_if;
  logic        rdy;
  logic        rollback_signal;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport master (
    input  rdy, rollback_signal, if_req, if_addr, ls_req, ls_wr, ls_size,
           ls_addr, ls_wdata, io_buffer_full, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output rdy, rollback_signal, if_req, if_addr, ls_req, ls_wr, ls_size,
           ls_addr, ls_wdata, io_buffer_full, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one byte-wide
// memory port, serialising each access into byte cycles with a 1-cycle read latency.
module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [2:0]  len_r, len_s;
  logic        last_grant_r, last_grant_s;
  logic        owner_r, owner_s;
  logic        wr_r, wr_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] rdata_r, rdata_s;

  logic        pick_ls_s;
  logic [1:0]  byte_sel_s;
  logic        io_stall_s;
  logic        done_ok_s;
  logic [31:0] mem_a_s;
  logic [7:0]  mem_dout_s;
  logic        mem_wr_s;
  logic        if_done_s;
  logic        ls_done_s;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Store to the UART window waits while its buffer is full.
  assign io_stall_s = (state_r == WRITE) && (addr_r[17:16] == 2'b11) && bus.io_buffer_full;

  // State and transfer-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      len_r        <= 3'd0;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      wr_r         <= 1'b0;
      addr_r       <= 32'h0;
      wdata_r      <= 32'h0;
      rdata_r      <= 32'h0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      len_r        <= len_s;
      last_grant_r <= last_grant_s;
      owner_r      <= owner_s;
      wr_r         <= wr_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      rdata_r      <= rdata_s;
    end
  end

  // Next-state, grant and read-byte capture.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    len_s        = len_r;
    last_grant_s = last_grant_r;
    owner_s      = owner_r;
    wr_s         = wr_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    rdata_s      = rdata_r;
    pick_ls_s    = bus.ls_req & (~bus.if_req | ~last_grant_r);
    byte_sel_s   = cnt_r[1:0] - 2'd1;
    if (!bus.rdy) begin
      state_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (!bus.rollback_signal && (bus.if_req || bus.ls_req)) begin
            owner_s      = pick_ls_s;
            last_grant_s = pick_ls_s;
            addr_s       = pick_ls_s ? bus.ls_addr : bus.if_addr;
            wr_s         = pick_ls_s & bus.ls_wr;
            len_s        = pick_ls_s ? size_to_len(bus.ls_size) : 3'd4;
            wdata_s      = pick_ls_s ? bus.ls_wdata : 32'h0;
            rdata_s      = 32'h0;
            cnt_s        = 3'd0;
            state_s      = (pick_ls_s && bus.ls_wr) ? WRITE : READ;
          end else begin
            state_s = IDLE;
          end
        end
        READ: begin
          if (bus.rollback_signal) begin
            state_s = IDLE;
            cnt_s   = 3'd0;
          end else begin
            // mem_din now holds the byte addressed one cycle earlier
            if (cnt_r != 3'd0) begin
              rdata_s[{byte_sel_s, 3'b000} +: 8] = bus.mem_din;
            end else begin
              rdata_s = rdata_r;
            end
            if (cnt_r == len_r) begin
              state_s = DONE;
              cnt_s   = 3'd0;
            end else begin
              cnt_s = cnt_r + 3'd1;
            end
          end
        end
        WRITE: begin
          if (io_stall_s) begin
            cnt_s = cnt_r;
          end else if (cnt_r == len_r - 3'd1) begin
            state_s = DONE;
            cnt_s   = 3'd0;
          end else begin
            cnt_s = cnt_r + 3'd1;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 3'd0;
        end
      endcase
    end
  end

  // Memory port drive and completion pulses.
  always_comb begin
    mem_a_s    = 32'h0;
    mem_dout_s = 8'h0;
    mem_wr_s   = 1'b0;
    if_done_s  = 1'b0;
    ls_done_s  = 1'b0;
    done_ok_s  = 1'b0;
    if (rst) begin
      mem_a_s = 32'h0;
    end else begin
      case (state_r)
        READ: begin
          // while frozen, re-present the byte whose data is still in flight
          if (!bus.rdy) begin
            mem_a_s = addr_r + {29'd0, (cnt_r == 3'd0) ? 3'd0 : (cnt_r - 3'd1)};
          end else if (cnt_r < len_r) begin
            mem_a_s = addr_r + {29'd0, cnt_r};
          end else begin
            mem_a_s = 32'h0;
          end
        end
        WRITE: begin
          mem_a_s    = addr_r + {29'd0, cnt_r};
          mem_dout_s = wdata_r[{cnt_r[1:0], 3'b000} +: 8];
          mem_wr_s   = bus.rdy & ~io_stall_s;
        end
        DONE: begin
          done_ok_s = bus.rdy & ~(bus.rollback_signal & ~wr_r);
          if_done_s = done_ok_s & ~owner_r;
          ls_done_s = done_ok_s & owner_r;
        end
        default: begin
          mem_a_s = 32'h0;
        end
      endcase
    end
  end

  assign bus.mem_a    = mem_a_s;
  assign bus.mem_dout = mem_dout_s;
  assign bus.mem_wr   = mem_wr_s;
  assign bus.if_done  = if_done_s;
  assign bus.ls_done  = ls_done_s;
  assign bus.if_data  = if_done_s ? rdata_r : 32'h0;
  assign bus.ls_rdata = ls_done_s ? rdata_r : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle-latency byte RAM model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] wr_mem [0:65535];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'h0000_1100: return 8'hA1;
      32'h0000_1101: return 8'hB2;
      32'h0000_1102: return 8'hC3;
      32'h0000_1103: return 8'hD4;
      32'h0000_2002: return 8'h5A;
      32'h0000_2003: return 8'h6B;
      default:       return 8'h00;
    endcase
  endfunction

  // RAM model: registered read data, byte write on mem_wr.
  always @(posedge clk) begin
    bus.mem_din <= rom_byte(bus.mem_a);
    if (bus.mem_wr) wr_mem[bus.mem_a[15:0]] <= bus.mem_dout;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rdy = 1'b1; bus.rollback_signal = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = 2'b00;
    bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    check_eq("rst_if_done", bus.if_done, 1'b0);
    check_eq("rst_ls_done", bus.ls_done, 1'b0);
    check_eq("rst_if_data", bus.if_data, 32'h0);
    check_eq("rst_ls_rdata", bus.ls_rdata, 32'h0);
    check_eq("rst_mem_a", bus.mem_a, 32'h0);
    check_eq("rst_mem_dout", bus.mem_dout, 8'h0);
    check_eq("rst_mem_wr", bus.mem_wr, 1'b0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic wait_done(output logic got_if, output logic got_ls, output logic seen);
    seen = 1'b0; got_if = 1'b0; got_ls = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.if_done || bus.ls_done) begin
        seen = 1'b1; got_if = bus.if_done; got_ls = bus.ls_done;
      end
    end
  endtask

  initial begin
    logic        g_if, g_ls, seen;
    logic [31:0] w;
    checks = 0; failures = 0;
    rst = 1'b1;
    idle_inputs();

    // IF word read, byte-by-byte timing
    do_reset();
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    @(negedge clk);
    check_eq("if_rd_a_t0", bus.mem_a, 32'h0);
    for (int j = 1; j <= 6; j++) begin
      next_cycle();
      @(negedge clk);
      check_eq("if_rd_a", bus.mem_a, (j <= 4) ? 32'h1000 + 32'(j - 1) : 32'h0);
      check_eq("if_rd_wr", bus.mem_wr, 1'b0);
      check_eq("if_rd_done", bus.if_done, (j == 6));
    end
    check_eq("if_rd_data", bus.if_data, 32'h0000_0513);
    next_cycle();
    bus.if_req = 1'b0;

    // Both requesting continuously: IF, LS, IF, LS
    do_reset();
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'b10; bus.ls_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      wait_done(g_if, g_ls, seen);
      check_eq("tie_seen", seen, 1'b1);
      check_eq("tie_order", {g_if, g_ls}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check_eq("tie_data", (k % 2 == 0) ? bus.if_data : bus.ls_rdata,
               (k % 2 == 0) ? 32'h0000_0513 : 32'h4433_2211);
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;

    // Byte load zero-extended; size 11 behaves as word
    do_reset();
    next_cycle();
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'b00; bus.ls_addr = 32'h1101;
    wait_done(g_if, g_ls, seen);
    check_eq("lb_done", {seen, g_ls}, 2'b11);
    check_eq("lb_data", bus.ls_rdata, 32'h0000_00B2);
    bus.ls_size = 2'b11; bus.ls_addr = 32'h1100;
    wait_done(g_if, g_ls, seen);
    check_eq("lw11_done", {seen, g_ls}, 2'b11);
    check_eq("lw11_data", bus.ls_rdata, 32'hD4C3_B2A1);
    bus.ls_req = 1'b0;

    // UART store stalled by a full buffer for 3 cycles
    do_reset();
    next_cycle();
    bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'b00;
    bus.ls_addr = 32'h0003_0000; bus.ls_wdata = 32'h41; bus.io_buffer_full = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      next_cycle();
      if (j == 4) bus.io_buffer_full = 1'b0;
      @(negedge clk);
      check_eq("io_wr", bus.mem_wr, (j == 4));
      check_eq("io_done", bus.ls_done, (j == 5));
      if (j == 4) begin
        check_eq("io_a", bus.mem_a, 32'h0003_0000);
        check_eq("io_dout", bus.mem_dout, 8'h41);
      end
    end
    next_cycle();
    bus.ls_req = 1'b0;

    // Rollback aborts a half load; pending IF granted in the following IDLE
    do_reset();
    next_cycle();
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'b01; bus.ls_addr = 32'h2002;
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    @(negedge clk);
    check_eq("rb_a1", bus.mem_a, 32'h2002);
    next_cycle();
    bus.rollback_signal = 1'b1;
    @(negedge clk);
    check_eq("rb_a2", bus.mem_a, 32'h2003);
    check_eq("rb_ls_done2", bus.ls_done, 1'b0);
    next_cycle();
    bus.rollback_signal = 1'b0; bus.ls_req = 1'b0;
    @(negedge clk);
    check_eq("rb_idle_a", bus.mem_a, 32'h0);
    check_eq("rb_ls_done3", bus.ls_done, 1'b0);
    for (int j = 4; j <= 9; j++) begin
      next_cycle();
      @(negedge clk);
      check_eq("rb_if_a", bus.mem_a, (j <= 7) ? 32'h1000 + 32'(j - 4) : 32'h0);
      check_eq("rb_if_done", bus.if_done, (j == 9));
      check_eq("rb_ls_quiet", bus.ls_done, 1'b0);
    end
    check_eq("rb_if_data", bus.if_data, 32'h0000_0513);
    next_cycle();
    bus.if_req = 1'b0;

    // Word store keeps going through rollback
    do_reset();
    w = 32'hDEAD_BEEF;
    next_cycle();
    bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'b10;
    bus.ls_addr = 32'h100; bus.ls_wdata = w;
    for (int j = 1; j <= 5; j++) begin
      next_cycle();
      if (j == 2) bus.rollback_signal = 1'b1;
      @(negedge clk);
      check_eq("st_wr", bus.mem_wr, (j <= 4));
      check_eq("st_done", bus.ls_done, (j == 5));
      if (j <= 4) begin
        check_eq("st_a", bus.mem_a, 32'h100 + 32'(j - 1));
        check_eq("st_dout", bus.mem_dout, w[8 * (j - 1) +: 8]);
      end
    end
    next_cycle();
    bus.rollback_signal = 1'b0; bus.ls_req = 1'b0;
    @(negedge clk);
    check_eq("st_mem", {wr_mem[16'h103], wr_mem[16'h102], wr_mem[16'h101], wr_mem[16'h100]}, w);

    // rdy low for 2 cycles stretches a word read by exactly 2 cycles
    do_reset();
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h1100;
    for (int j = 1; j <= 8; j++) begin
      next_cycle();
      bus.rdy = !(j == 3 || j == 4);
      @(negedge clk);
      check_eq("rdy_done", bus.if_done, (j == 8));
      check_eq("rdy_wr", bus.mem_wr, 1'b0);
    end
    check_eq("rdy_data", bus.if_data, 32'hD4C3_B2A1);
    next_cycle();
    bus.if_req = 1'b0; bus.rdy = 1'b1;

    // Reset in the middle of a store aborts it with no completion
    do_reset();
    next_cycle();
    bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'b10;
    bus.ls_addr = 32'h200; bus.ls_wdata = 32'h1234_5678;
    next_cycle();
    @(negedge clk);
    check_eq("mid_wr_active", bus.mem_wr, 1'b1);
    do_reset();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check_eq("mid_no_done", bus.ls_done, 1'b0);
      check_eq("mid_no_wr", bus.mem_wr, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
